// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register selectors, hazard-controller state and latch control bundle.
package cpu_types_pkg;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        HALT  = 2'd2
    } hzd_state_t;

    // Bit order matches the PC/latch control outputs from front to back of the pipe.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_sRST;
        logic idex_en;
        logic idex_sRST;
        logic exmem_en;
        logic memwb_en;
    } latch_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, latch/PC controls and halt indication out.
interface pipeline_hazard_ctrl_if;
    import cpu_types_pkg::*;

    logic     ihit;
    logic     dhit;
    regbits_t id_rsel1;
    regbits_t id_rsel2;
    regbits_t idex_wsel_l;
    logic     idex_regen_l;
    logic     idex_dmemREN_l;
    logic     ex_redirect;
    logic     exmem_dmemREN_l;
    logic     exmem_dmemWEN_l;
    logic     memwb_hlt_l;

    logic     pc_en;
    logic     ifid_en;
    logic     ifid_sRST;
    logic     idex_en;
    logic     idex_sRST;
    logic     exmem_en;
    logic     memwb_en;
    logic     halted;

    modport master (
        input  ihit, dhit, id_rsel1, id_rsel2, idex_wsel_l, idex_regen_l, idex_dmemREN_l,
               ex_redirect, exmem_dmemREN_l, exmem_dmemWEN_l, memwb_hlt_l,
        output pc_en, ifid_en, ifid_sRST, idex_en, idex_sRST, exmem_en, memwb_en, halted
    );

    modport slave (
        output ihit, dhit, id_rsel1, id_rsel2, idex_wsel_l, idex_regen_l, idex_dmemREN_l,
               ex_redirect, exmem_dmemREN_l, exmem_dmemWEN_l, memwb_hlt_l,
        input  pc_en, ifid_en, ifid_sRST, idex_en, idex_sRST, exmem_en, memwb_en, halted
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low reset and synchronous clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: Mealy latch/PC controls from a RUN/MWAIT/HALT state,
// plus saturating stall, flush and dcache-wait counters.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    pipeline_hazard_ctrl_if.master hif,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt,
    output logic [CNT_W-1:0]       mwait_cnt
);

    hzd_state_t  state, next_state;
    latch_ctrl_t ctrl;
    logic        dreq, luse, resolve;
    logic        inc_stall, inc_flush, inc_mwait;

    assign dreq = hif.exmem_dmemREN_l | hif.exmem_dmemWEN_l;
    assign luse = hif.idex_dmemREN_l & hif.idex_regen_l & (hif.idex_wsel_l != '0) &
                  ((hif.idex_wsel_l == hif.id_rsel1) | (hif.idex_wsel_l == hif.id_rsel2));

    always_comb begin
        next_state = state;
        ctrl       = '0;
        resolve    = 1'b0;
        inc_stall  = 1'b0;
        inc_flush  = 1'b0;
        inc_mwait  = 1'b0;

        unique case (state)
            RUN: begin
                if (hif.memwb_hlt_l) begin
                    next_state = HALT;
                end else if (dreq && !hif.dhit) begin
                    next_state = MWAIT;
                    inc_mwait  = 1'b1;
                end else begin
                    resolve = 1'b1;
                end
            end
            MWAIT: begin
                if (!hif.dhit) begin
                    inc_mwait = 1'b1;
                end else begin
                    next_state = RUN;
                    resolve    = 1'b1;
                end
            end
            HALT: ;
            default: next_state = RUN;
        endcase

        // Redirect outranks load-use: the dependent instruction is on the wrong path.
        if (resolve) begin
            if (hif.ex_redirect) begin
                ctrl      = '1;
                inc_flush = 1'b1;
            end else if (luse) begin
                ctrl.idex_sRST = 1'b1;
                ctrl.idex_en   = 1'b1;
                ctrl.exmem_en  = 1'b1;
                ctrl.memwb_en  = 1'b1;
                inc_stall      = 1'b1;
            end else if (hif.ihit) begin
                ctrl.pc_en    = 1'b1;
                ctrl.ifid_en  = 1'b1;
                ctrl.idex_en  = 1'b1;
                ctrl.exmem_en = 1'b1;
                ctrl.memwb_en = 1'b1;
            end else begin
                ctrl.ifid_sRST = 1'b1;
                ctrl.idex_sRST = 1'b1;
                ctrl.exmem_en  = 1'b1;
                ctrl.memwb_en  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    assign hif.pc_en     = nRST & ctrl.pc_en;
    assign hif.ifid_en   = nRST & ctrl.ifid_en;
    assign hif.ifid_sRST = nRST & ctrl.ifid_sRST;
    assign hif.idex_en   = nRST & ctrl.idex_en;
    assign hif.idex_sRST = nRST & ctrl.idex_sRST;
    assign hif.exmem_en  = nRST & ctrl.exmem_en;
    assign hif.memwb_en  = nRST & ctrl.memwb_en;
    assign hif.halted    = (state == HALT);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK(CLK), .nRST(nRST), .inc(inc_stall), .clear(1'b0), .count(stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK(CLK), .nRST(nRST), .inc(inc_flush), .clear(1'b0), .count(flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mwait_cnt (
        .CLK(CLK), .nRST(nRST), .inc(inc_mwait), .clear(1'b0), .count(mwait_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: single-cycle vector table, directed multi-cycle
// sequences and random stimulus against an action-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    // Control vector order: pc_en, ifid_en, ifid_sRST, idex_en, idex_sRST, exmem_en, memwb_en
    localparam logic [6:0] C_GO     = 7'b1101011;
    localparam logic [6:0] C_BUBBLE = 7'b0010111;
    localparam logic [6:0] C_STALL  = 7'b0001111;
    localparam logic [6:0] C_FLUSH  = 7'b1111111;
    localparam logic [6:0] C_ZERO   = 7'b0000000;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] wsel;
        logic       regen;
        logic       dren;
        logic       redir;
        logic       exren;
        logic       exwen;
        logic       hlt;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] ctrl;
        int         s;
        int         f;
        int         m;
        logic       h;
        string      nm;
    } vec_t;

    typedef enum int {A_IDLE, A_HALTING, A_FREEZE, A_FLUSH, A_STALL, A_GO, A_BUBBLE} act_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic [CW-1:0] stall_cnt, flush_cnt, mwait_cnt;

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .hif      (bus.master),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
        .mwait_cnt(mwait_cnt)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    int m_stall, m_flush, m_mwait;
    bit m_wait, m_halt;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic ihit, input logic dhit, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] wsel, input logic regen,
                               input logic dren, input logic redir, input logic exren,
                               input logic exwen, input logic hlt);
        in_t v;
        v.ihit = ihit; v.dhit = dhit; v.rs1 = rs1; v.rs2 = rs2; v.wsel = wsel;
        v.regen = regen; v.dren = dren; v.redir = redir; v.exren = exren;
        v.exwen = exwen; v.hlt = hlt;
        return v;
    endfunction

    task automatic add(input in_t v, input logic [6:0] c, input int s, input int f,
                       input int m, input logic h, input string nm);
        vec_t e;
        e.in = v; e.ctrl = c; e.s = s; e.f = f; e.m = m; e.h = h; e.nm = nm;
        tbl.push_back(e);
    endtask

    task automatic apply(input in_t v);
        bus.ihit            = v.ihit;
        bus.dhit            = v.dhit;
        bus.id_rsel1        = v.rs1;
        bus.id_rsel2        = v.rs2;
        bus.idex_wsel_l     = v.wsel;
        bus.idex_regen_l    = v.regen;
        bus.idex_dmemREN_l  = v.dren;
        bus.ex_redirect     = v.redir;
        bus.exmem_dmemREN_l = v.exren;
        bus.exmem_dmemWEN_l = v.exwen;
        bus.memwb_hlt_l     = v.hlt;
    endtask

    function automatic logic [6:0] got_ctrl();
        return {bus.pc_en, bus.ifid_en, bus.ifid_sRST, bus.idex_en, bus.idex_sRST,
                bus.exmem_en, bus.memwb_en};
    endfunction

    function automatic int sat_inc(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    function automatic act_t model_act(input in_t v);
        bit dep;
        if (m_halt) return A_IDLE;
        if (!m_wait && v.hlt) return A_HALTING;
        if (m_wait ? !v.dhit : ((v.exren || v.exwen) && !v.dhit)) return A_FREEZE;
        dep = v.dren && v.regen && (v.wsel != 0) && (v.wsel == v.rs1 || v.wsel == v.rs2);
        if (v.redir) return A_FLUSH;
        if (dep) return A_STALL;
        return v.ihit ? A_GO : A_BUBBLE;
    endfunction

    function automatic logic [6:0] act_ctrl(input act_t a);
        case (a)
            A_FLUSH:  return C_FLUSH;
            A_STALL:  return C_STALL;
            A_GO:     return C_GO;
            A_BUBBLE: return C_BUBBLE;
            default:  return C_ZERO;
        endcase
    endfunction

    function automatic void model_reset();
        m_stall = 0; m_flush = 0; m_mwait = 0; m_wait = 0; m_halt = 0;
    endfunction

    // Holds reset across one edge, checking that everything is forced low; entered and left at edge+1.
    task automatic do_reset();
        apply('0);
        nRST = 1'b0;
        #1;
        chk("rst ctrl", 32'(got_ctrl()), 32'(C_ZERO));
        chk("rst cnts", {26'd0, stall_cnt, flush_cnt, mwait_cnt}, 32'd0);
        chk("rst halted", 32'(bus.halted), 32'd0);
        model_reset();
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    // One clock against the reference model; starts and ends at edge+1.
    task automatic cycle(input in_t v, input string nm);
        act_t a;
        apply(v);
        #1;
        a = model_act(v);
        chk({nm, " ctrl"}, 32'(got_ctrl()), 32'(act_ctrl(a)));
        case (a)
            A_HALTING: m_halt = 1;
            A_FREEZE:  begin m_wait = 1; m_mwait = sat_inc(m_mwait); end
            A_FLUSH:   begin m_wait = 0; m_flush = sat_inc(m_flush); end
            A_STALL:   begin m_wait = 0; m_stall = sat_inc(m_stall); end
            A_GO, A_BUBBLE: m_wait = 0;
            default: ;
        endcase
        @(posedge CLK); #1;
        chk({nm, " cnts"}, {26'd0, stall_cnt, flush_cnt, mwait_cnt},
            {26'd0, CW'(m_stall), CW'(m_flush), CW'(m_mwait)});
        chk({nm, " halted"}, 32'(bus.halted), 32'(m_halt));
    endtask

    in_t  n_go, luse_v, miss, hit, rv;
    vec_t e;

    initial begin
        apply('0);
        model_reset();

        // ihit dhit rs1 rs2 wsel regen dren redir exren exwen hlt
        add(mk(1,0,1,2,5,1,1,0,0,0,0), C_GO,     0,0,0,0, "normal");
        add(mk(0,0,1,2,5,1,1,0,0,0,0), C_BUBBLE, 0,0,0,0, "imiss");
        add(mk(1,0,3,0,3,1,1,0,0,0,0), C_STALL,  1,0,0,0, "luse rs1");
        add(mk(1,0,4,3,3,1,1,0,0,0,0), C_STALL,  1,0,0,0, "luse rs2");
        add(mk(0,0,4,3,3,1,1,0,0,0,0), C_STALL,  1,0,0,0, "luse imiss");
        add(mk(1,0,0,0,0,1,1,0,0,0,0), C_GO,     0,0,0,0, "luse r0");
        add(mk(1,0,3,3,3,0,1,0,0,0,0), C_GO,     0,0,0,0, "no regen");
        add(mk(1,0,3,0,3,1,1,1,0,0,0), C_FLUSH,  0,1,0,0, "redir+luse");
        add(mk(0,0,0,0,0,0,0,1,0,0,0), C_FLUSH,  0,1,0,0, "redir imiss");
        add(mk(1,0,0,0,0,0,0,0,1,0,0), C_ZERO,   0,0,1,0, "load miss");
        add(mk(1,1,0,0,0,0,0,0,0,1,0), C_GO,     0,0,0,0, "store hit");
        add(mk(1,0,0,0,0,0,0,1,0,1,0), C_ZERO,   0,0,1,0, "miss+redir");
        add(mk(1,1,0,0,0,0,0,0,0,0,1), C_ZERO,   0,0,0,1, "halt");
        add(mk(1,0,3,0,3,1,1,1,1,0,1), C_ZERO,   0,0,0,1, "halt prio");

        foreach (tbl[i]) begin
            e = tbl[i];
            do_reset();
            apply(e.in);
            #1;
            chk({"tbl ", e.nm, " ctrl"}, 32'(got_ctrl()), 32'(e.ctrl));
            @(posedge CLK); #1;
            chk({"tbl ", e.nm, " cnts"}, {26'd0, stall_cnt, flush_cnt, mwait_cnt},
                {26'd0, CW'(e.s), CW'(e.f), CW'(e.m)});
            chk({"tbl ", e.nm, " halted"}, 32'(bus.halted), 32'(e.h));
        end

        n_go   = mk(1,0,0,0,0,0,0,0,0,0,0);
        luse_v = mk(1,0,3,0,3,1,1,0,0,0,0);
        miss   = mk(1,0,0,0,0,0,0,0,1,0,0);
        hit    = mk(1,1,0,0,0,0,0,0,1,0,0);

        // Single bubble then the pipe resumes.
        do_reset();
        cycle(luse_v, "lu1");
        cycle(n_go, "lu2");
        chk("lu stall_cnt", 32'(stall_cnt), 32'd1);

        // Three-cycle dcache miss, then the hit cycle releases everything.
        do_reset();
        repeat (3) cycle(miss, "miss");
        chk("miss mwait_cnt", 32'(mwait_cnt), 32'd3);
        apply(hit); #1;
        chk("miss hit ctrl", 32'(got_ctrl()), 32'(C_GO));
        cycle(hit, "miss hit");
        cycle(mk(1,0,0,0,0,0,0,0,0,0,0), "miss run");

        // Redirect held through a miss is acted on in the hit cycle.
        do_reset();
        rv = miss; rv.redir = 1;
        repeat (2) cycle(rv, "rmiss");
        chk("rmiss flush0", 32'(flush_cnt), 32'd0);
        rv = hit; rv.redir = 1;
        apply(rv); #1;
        chk("rmiss hit ctrl", 32'(got_ctrl()), 32'(C_FLUSH));
        cycle(rv, "rmiss hit");
        chk("rmiss flush1", 32'(flush_cnt), 32'd1);

        // Halt is sticky until reset.
        do_reset();
        cycle(mk(1,1,0,0,0,0,0,0,0,0,1), "halt");
        chk("halt sticky", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 6; i++) begin
            rv = in_t'($urandom);
            rv.hlt = 0;
            cycle(rv, "halted");
        end
        do_reset();
        chk("halt cleared", 32'(bus.halted), 32'd0);

        // Saturation, then an async reset in the middle of a miss.
        repeat (5) cycle(luse_v, "sat");
        chk("sat stall_cnt", 32'(stall_cnt), 32'd3);
        repeat (2) cycle(miss, "pre-arst");
        nRST = 1'b0;
        #1;
        chk("arst ctrl", 32'(got_ctrl()), 32'(C_ZERO));
        chk("arst cnts", {26'd0, stall_cnt, flush_cnt, mwait_cnt}, 32'd0);
        model_reset();
        @(posedge CLK); #1;
        nRST = 1'b1;
        cycle(n_go, "post-arst");

        // Random stimulus with narrow register selectors to provoke dependencies.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 199) do_reset();
            rv       = in_t'($urandom);
            rv.rs1   = 5'($urandom_range(0, 3));
            rv.rs2   = 5'($urandom_range(0, 3));
            rv.wsel  = 5'($urandom_range(0, 3));
            rv.hlt   = ($urandom_range(0, 99) == 0);
            rv.redir = ($urandom_range(0, 3) == 0);
            cycle(rv, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
